// File: rtl/mmp_iddmm_arb_if.sv
// Bundle between the requesters, the round-robin arbiter and the shared Montgomery multiplier.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mmp_iddmm_arb_if #(
    parameter int K    = 128,
    parameter int N    = 16,
    parameter int NREQ = 4
);
    localparam int AW = $clog2(N);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   gnt;
    logic [AW-1:0]     op_addr;
    logic [NREQ*K-1:0] op_x;
    logic [NREQ*K-1:0] op_y;
    logic [NREQ*K-1:0] op_m;
    logic [NREQ*K-1:0] op_m1;
    logic [NREQ-1:0]   res_val;
    logic [K-1:0]      res_word;
    logic [NREQ-1:0]   done;
    logic              err;
    logic              busy;
    logic [2:0]        mm_wr_ena;
    logic [AW-1:0]     mm_wr_addr;
    logic [K-1:0]      mm_wr_x;
    logic [K-1:0]      mm_wr_y;
    logic [K-1:0]      mm_wr_m;
    logic [K-1:0]      mm_wr_m1;
    logic              mm_task_req;
    logic              mm_task_end;
    logic              mm_task_grant;
    logic [K-1:0]      mm_task_res;

    modport slave (
        input  req, op_x, op_y, op_m, op_m1, mm_task_end, mm_task_grant, mm_task_res,
        output gnt, op_addr, res_val, res_word, done, err, busy,
               mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req
    );

    modport master (
        output req, op_x, op_y, op_m, op_m1, mm_task_end, mm_task_grant, mm_task_res,
        input  gnt, op_addr, res_val, res_word, done, err, busy,
               mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req
    );
endinterface

// File: rtl/mmp_iddmm_arb.sv
// Round-robin sequencer that shares one Montgomery multiplier among NREQ requesters:
// load operands, run the multiplier, forward result words, pulse done, rotate priority.
module mmp_iddmm_arb #(
    parameter int K    = 128,
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic           clk,
    input  logic           rst,
    mmp_iddmm_arb_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(N + 2);
    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [CW-1:0] CNT_N     = CW'(N);
    localparam logic [CW-1:0] CNT_SAT   = CW'(N + 1);
    localparam logic [PW-1:0] REQ_LAST  = PW'(NREQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   win_q, win_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      ena_q, ena_d;
    logic            task_req_q, task_req_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;

    // Scan ptr+1, ptr+2, ... with wrap; first requester found wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = ptr_q;
        for (int off = 0; off < NREQ; off++) begin
            cand = (cand == REQ_LAST) ? '0 : cand + 1'b1;
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        addr_d     = addr_q;
        ena_d      = ena_q;
        task_req_d = task_req_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    win_d       = pick;
                    ena_d       = 3'b111;
                    addr_d      = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (addr_q == ADDR_LAST) begin
                    ena_d   = 3'b000;
                    state_d = S_GAP;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_GAP: begin
                cnt_d      = '0;
                task_req_d = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                // A word arriving together with task_end still counts.
                if (bus.mm_task_grant && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (bus.mm_task_end) begin
                    task_req_d = 1'b0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                ptr_d   = win_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            win_q      <= '0;
            ptr_q      <= REQ_LAST;
            addr_q     <= '0;
            ena_q      <= 3'b000;
            task_req_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            ena_q      <= ena_d;
            task_req_q <= task_req_d;
            cnt_q      <= cnt_d;
        end
    end

    // Operand muxes: mask each requester's slice by its grant bit, then OR together.
    logic [NREQ-1:0][K-1:0] x_sl, y_sl, m_sl, m1_sl;
    logic [K-1:0]           wr_x, wr_y, wr_m, wr_m1;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign x_sl[gi]  = bus.op_x[gi*K +: K]  & {K{gnt_q[gi]}};
        assign y_sl[gi]  = bus.op_y[gi*K +: K]  & {K{gnt_q[gi]}};
        assign m_sl[gi]  = bus.op_m[gi*K +: K]  & {K{gnt_q[gi]}};
        assign m1_sl[gi] = bus.op_m1[gi*K +: K] & {K{gnt_q[gi]}};
    end

    always_comb begin
        wr_x  = '0;
        wr_y  = '0;
        wr_m  = '0;
        wr_m1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            wr_x  = wr_x  | x_sl[i];
            wr_y  = wr_y  | y_sl[i];
            wr_m  = wr_m  | m_sl[i];
            wr_m1 = wr_m1 | m1_sl[i];
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.op_addr     = addr_q;
    assign bus.mm_wr_addr  = addr_q;
    assign bus.mm_wr_ena   = ena_q;
    assign bus.mm_wr_x     = wr_x;
    assign bus.mm_wr_y     = wr_y;
    assign bus.mm_wr_m     = wr_m;
    assign bus.mm_wr_m1    = wr_m1;
    assign bus.mm_task_req = task_req_q;
    assign bus.res_val     = (state_q == S_RUN && bus.mm_task_grant) ? gnt_q : '0;
    assign bus.res_word    = bus.mm_task_res;
    assign bus.done        = (state_q == S_DONE) ? gnt_q : '0;
    assign bus.err         = (state_q == S_DONE) && (cnt_q != CNT_N);
    assign bus.busy        = (state_q != S_IDLE);
endmodule

// File: tb/tb_mmp_iddmm_arb.sv
// Bench for mmp_iddmm_arb: stub multiplier returns x^y^m^m1 per captured word; a scoreboard
// of expected grants, result words and done/err pulses is checked by a separate monitor.
module tb_mmp_iddmm_arb;
    localparam int K    = 128;
    localparam int N    = 16;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mmp_iddmm_arb_if #(.K(K), .N(N), .NREQ(NREQ)) bus ();

    mmp_iddmm_arb #(.K(K), .N(N), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [K-1:0] opw(input int kind, input int r, input int a);
        return {8'(kind + 1), 8'(r), 8'(a), 8'hC3,
                32'hDEADBEEF ^ 32'(a * 7919 + r * 104729 + kind * 31),
                64'h0123456789ABCDEF + 64'(a * r + kind)};
    endfunction

    function automatic logic [K-1:0] m1w(input int r);
        return {8'(r), 120'h328289a3442afa98c0d743199fd3cc};
    endfunction

    function automatic logic [K-1:0] ew(input int w, input int j);
        return opw(0, w, j) ^ opw(1, w, j) ^ opw(2, w, j) ^ m1w(w);
    endfunction

    // Requesters answer the current op_addr combinationally.
    always_comb begin
        bus.op_x  = '0;
        bus.op_y  = '0;
        bus.op_m  = '0;
        bus.op_m1 = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.op_x[i*K +: K]  = opw(0, i, int'(bus.op_addr));
            bus.op_y[i*K +: K]  = opw(1, i, int'(bus.op_addr));
            bus.op_m[i*K +: K]  = opw(2, i, int'(bus.op_addr));
            bus.op_m1[i*K +: K] = m1w(i);
        end
    end

    // Stub multiplier RAMs.
    logic [K-1:0] mem_x [N];
    logic [K-1:0] mem_y [N];
    logic [K-1:0] mem_m [N];
    always @(posedge clk) begin
        if (bus.mm_wr_ena[2]) mem_x[bus.mm_wr_addr] <= bus.mm_wr_x;
        if (bus.mm_wr_ena[1]) mem_y[bus.mm_wr_addr] <= bus.mm_wr_y;
        if (bus.mm_wr_ena[0]) mem_m[bus.mm_wr_addr] <= bus.mm_wr_m;
    end

    int stub_words = 16;
    bit end_same   = 1'b1;
    int stray_req  = 0;
    int stray_done = 0;

    initial begin
        int idx;
        int wt;
        bit fin;
        idx = 0; wt = 0; fin = 1'b0;
        bus.mm_task_grant = 1'b0;
        bus.mm_task_end   = 1'b0;
        bus.mm_task_res   = '0;
        forever begin
            @(posedge clk); #1;
            bus.mm_task_grant = 1'b0;
            bus.mm_task_end   = 1'b0;
            if (rst || !bus.mm_task_req) begin
                idx = 0; wt = 0; fin = 1'b0;
                if (!rst && stray_req != stray_done) begin
                    bus.mm_task_grant = 1'b1;
                    bus.mm_task_end   = 1'b1;
                    bus.mm_task_res   = {K{1'b1}};
                    stray_done++;
                end
            end else if (!fin) begin
                if (wt < 3) begin
                    wt++;
                end else if (idx < stub_words) begin
                    bus.mm_task_grant = 1'b1;
                    bus.mm_task_res   = mem_x[idx] ^ mem_y[idx] ^ mem_m[idx] ^ bus.mm_wr_m1;
                    idx++;
                    if (idx == stub_words && end_same) begin
                        bus.mm_task_end = 1'b1;
                        fin = 1'b1;
                    end
                end else begin
                    bus.mm_task_end = 1'b1;
                    fin = 1'b1;
                end
            end
        end
    end

    // Scoreboard queues.
    logic [NREQ-1:0]   gnt_sb[$];
    logic [NREQ+K-1:0] word_sb[$];
    logic [NREQ:0]     done_sb[$];

    task automatic exp_job(input int w, input int words, input bit with_done);
        gnt_sb.push_back(NREQ'(1 << w));
        if (with_done) begin
            for (int j = 0; j < words; j++) word_sb.push_back({NREQ'(1 << w), ew(w, j)});
            done_sb.push_back({NREQ'(1 << w), (words != N)});
        end
    endtask

    // Monitor.
    initial begin
        logic [NREQ-1:0]   gnt_prev;
        logic [NREQ-1:0]   eg;
        logic [NREQ+K-1:0] ewd;
        logic [NREQ:0]     ed;
        gnt_prev = '0;
        forever begin
            @(negedge clk);
            if (bus.gnt != '0 && gnt_prev == '0) begin
                checks++;
                if (gnt_sb.size() == 0) begin
                    errors++;
                    $display("FAIL gnt unexpected got %b", bus.gnt);
                end else begin
                    eg = gnt_sb.pop_front();
                    if (bus.gnt != eg) begin
                        errors++;
                        $display("FAIL gnt got %b required %b", bus.gnt, eg);
                    end else $display("grant %b", bus.gnt);
                end
            end
            if (bus.gnt != '0 && gnt_prev != '0) begin
                checks++;
                if (bus.gnt != gnt_prev) begin
                    errors++;
                    $display("FAIL gnt_hold got %b required %b", bus.gnt, gnt_prev);
                end
            end
            if (bus.res_val != '0) begin
                checks++;
                if (word_sb.size() == 0) begin
                    errors++;
                    $display("FAIL res unexpected got val=%b word=%h", bus.res_val, bus.res_word);
                end else begin
                    ewd = word_sb.pop_front();
                    if ({bus.res_val, bus.res_word} != ewd) begin
                        errors++;
                        $display("FAIL res got val=%b word=%h required val=%b word=%h",
                                 bus.res_val, bus.res_word, ewd[NREQ+K-1:K], ewd[K-1:0]);
                    end else $display("res val=%b word=%h", bus.res_val, bus.res_word);
                end
            end
            if (bus.done != '0) begin
                checks++;
                if (done_sb.size() == 0) begin
                    errors++;
                    $display("FAIL done unexpected got done=%b err=%b", bus.done, bus.err);
                end else begin
                    ed = done_sb.pop_front();
                    if ({bus.done, bus.err} != ed) begin
                        errors++;
                        $display("FAIL done got done=%b err=%b required done=%b err=%b",
                                 bus.done, bus.err, ed[NREQ:1], ed[0]);
                    end else $display("done=%b err=%b", bus.done, bus.err);
                end
            end
            gnt_prev = bus.gnt;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, req_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},      64'(bus.gnt),         64'd0);
        chk({tag, "_busy"},     64'(bus.busy),        64'd0);
        chk({tag, "_done"},     64'(bus.done),        64'd0);
        chk({tag, "_err"},      64'(bus.err),         64'd0);
        chk({tag, "_res_val"},  64'(bus.res_val),     64'd0);
        chk({tag, "_task_req"}, 64'(bus.mm_task_req), 64'd0);
        chk({tag, "_wr_ena"},   64'(bus.mm_wr_ena),   64'd0);
        chk({tag, "_addr"},     64'(bus.op_addr),     64'd0);
    endtask

    task automatic run_dones(input int n, input bit rel);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200 * n) begin
            @(negedge clk);
            cyc++;
            if (bus.done != '0) begin
                got++;
                if (rel) bus.req = bus.req & ~bus.done;
            end
        end
        bus.req = '0;
        chk("job_count", 64'(got), 64'(n));
    endtask

    task automatic wait_task_req();
        int cyc;
        cyc = 0;
        while (!bus.mm_task_req && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("task_req_seen", 64'(bus.mm_task_req), 64'd1);
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Two requests from reset: 0 then 1.
        exp_job(0, 16, 1'b1);
        exp_job(1, 16, 1'b1);
        bus.req = 4'b0011;
        run_dones(2, 1'b1);

        // Requester 2 drops req during RUN; its job still completes, then 3.
        exp_job(2, 16, 1'b1);
        exp_job(3, 16, 1'b1);
        bus.req = 4'b1100;
        wait_task_req();
        bus.req[2] = 1'b0;
        run_dones(2, 1'b1);

        // All four held for eight jobs: strict rotation 0..3 twice.
        for (int i = 0; i < 8; i++) exp_job(i % 4, 16, 1'b1);
        bus.req = 4'b1111;
        run_dones(8, 1'b0);

        // Single requester 0.
        exp_job(0, 16, 1'b1);
        bus.req = 4'b0001;
        run_dones(1, 1'b1);

        // Stray multiplier strobes while idle must be ignored.
        repeat (2) @(negedge clk);
        stray_req++;
        @(negedge clk);
        chk("stray_res_val", 64'(bus.res_val), 64'd0);
        chk("stray_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("stray_done", 64'(bus.done), 64'd0);
        chk("stray_busy2", 64'(bus.busy), 64'd0);

        // Short result (15 words) flags err; full result with separate end does not.
        stub_words = 15;
        exp_job(1, 15, 1'b1);
        bus.req = 4'b0010;
        run_dones(1, 1'b1);
        stub_words = 16;
        end_same   = 1'b0;
        exp_job(1, 16, 1'b1);
        bus.req = 4'b0010;
        run_dones(1, 1'b1);
        end_same = 1'b1;

        // Reset mid-RUN aborts without done; priority restarts at requester 0.
        exp_job(2, 16, 1'b0);
        bus.req = 4'b0100;
        wait_task_req();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        exp_job(0, 16, 1'b1);
        exp_job(2, 16, 1'b1);
        bus.req = 4'b0101;
        run_dones(2, 1'b1);

        repeat (5) @(negedge clk);
        chk("gnt_sb_left",  64'(gnt_sb.size()),  64'd0);
        chk("word_sb_left", 64'(word_sb.size()), 64'd0);
        chk("done_sb_left", 64'(done_sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
